// File: rtl/seq_stage_sequencer.sv
// Y86 SEQ stage sequencer: enables one stage per cycle and owns PC, status code and retire count.
// 5 cycles/instr, 6+W with memory; MEMORY holds mem_req until mem_ack (bounded when SEQ_WATCHDOG_EN).
module seq_stage_sequencer #(
  parameter int unsigned        ADDR_W      = 64,
  parameter int unsigned        CNT_W       = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC    = '0,
  parameter int unsigned        WDOG_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [3:0]        icode,
  input  logic              instr_invalid,
  input  logic              imem_error,
  input  logic              mem_ack,
  input  logic              dmem_error,
  input  logic [ADDR_W-1:0] pc_next,
  output logic [ADDR_W-1:0] pc,
  output logic              fe_en,
  output logic              de_en,
  output logic              ex_en,
  output logic              me_en,
  output logic              wb_en,
  output logic              pc_en,
  output logic              mem_req,
  output logic [1:0]        stat,
  output logic              halted,
  output logic [CNT_W-1:0]  retired
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_FETCH     = 3'd1;
  localparam logic [2:0] S_DECODE    = 3'd2;
  localparam logic [2:0] S_EXECUTE   = 3'd3;
  localparam logic [2:0] S_MEMORY    = 3'd4;
  localparam logic [2:0] S_WRITEBACK = 3'd5;
  localparam logic [2:0] S_PCUPD     = 3'd6;
  localparam logic [2:0] S_HALT      = 3'd7;

  localparam logic [1:0] STAT_AOK = 2'b00;
  localparam logic [1:0] STAT_HLT = 2'b01;
  localparam logic [1:0] STAT_ADR = 2'b10;
  localparam logic [1:0] STAT_INS = 2'b11;

  if (WDOG_CYCLES == 0) begin : g_wdog_param_chk
    $error("WDOG_CYCLES must be at least 1");
  end

  logic [2:0]        state_q, state_d;
  logic [1:0]        stat_q, stat_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [CNT_W-1:0]  retired_q, retired_d;
  logic [5:0]        en_q, en_d;
  logic              mem_req_q, mem_req_d;
  logic              halted_q, halted_d;
  logic              mem_icode;
  logic              wdog_expired;

  // mrmovq, rmmovq, call, ret, pushq, popq touch data memory
  assign mem_icode = icode inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};

`ifdef SEQ_WATCHDOG_EN
  localparam int unsigned       WDOG_W    = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);

  logic [WDOG_W-1:0] wdog_q, wdog_d;

  // Held at zero outside MEMORY, so every MEMORY visit starts a fresh count.
  assign wdog_d       = (state_q == S_MEMORY) ? wdog_q + 1'b1 : '0;
  assign wdog_expired = (wdog_q == WDOG_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_d;
    end
  end
`else
  assign wdog_expired = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    stat_d    = stat_q;
    pc_d      = pc_q;
    retired_d = retired_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (imem_error) begin
          stat_d  = STAT_ADR;
          state_d = S_HALT;
        end else if (instr_invalid) begin
          stat_d  = STAT_INS;
          state_d = S_HALT;
        end else if (icode == 4'h0) begin
          stat_d  = STAT_HLT;
          state_d = S_HALT;
        end else begin
          state_d = S_DECODE;
        end
      end
      S_DECODE:  state_d = S_EXECUTE;
      S_EXECUTE: state_d = mem_icode ? S_MEMORY : S_WRITEBACK;
      S_MEMORY: begin
        // An ack in the expiry cycle takes precedence over the watchdog.
        if (mem_ack) begin
          if (dmem_error) begin
            stat_d  = STAT_ADR;
            state_d = S_HALT;
          end else begin
            state_d = S_WRITEBACK;
          end
        end else if (wdog_expired) begin
          stat_d  = STAT_ADR;
          state_d = S_HALT;
        end
      end
      S_WRITEBACK: state_d = S_PCUPD;
      S_PCUPD: begin
        pc_d      = pc_next;
        retired_d = retired_q + 1'b1;
        state_d   = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered copies of the next-state decode so nothing is input-combinational.
  always_comb begin
    en_d[5]   = (state_d == S_FETCH);
    en_d[4]   = (state_d == S_DECODE);
    en_d[3]   = (state_d == S_EXECUTE);
    en_d[2]   = (state_d == S_MEMORY);
    en_d[1]   = (state_d == S_WRITEBACK);
    en_d[0]   = (state_d == S_PCUPD);
    mem_req_d = (state_d == S_MEMORY);
    halted_d  = (state_d == S_HALT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      stat_q    <= STAT_AOK;
      pc_q      <= RESET_PC;
      retired_q <= '0;
      en_q      <= '0;
      mem_req_q <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      stat_q    <= stat_d;
      pc_q      <= pc_d;
      retired_q <= retired_d;
      en_q      <= en_d;
      mem_req_q <= mem_req_d;
      halted_q  <= halted_d;
    end
  end

  assign pc      = pc_q;
  assign stat    = stat_q;
  assign retired = retired_q;
  assign fe_en   = en_q[5];
  assign de_en   = en_q[4];
  assign ex_en   = en_q[3];
  assign me_en   = en_q[2];
  assign wb_en   = en_q[1];
  assign pc_en   = en_q[0];
  assign mem_req = mem_req_q;
  assign halted  = halted_q;

endmodule

// File: tb/tb_seq_stage_sequencer.sv
// Directed bench for seq_stage_sequencer: per-instruction vector table plus hand-written multi-cycle sequences.
module tb_seq_stage_sequencer;

  localparam logic [63:0] RPC = 64'h40;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  icode;
  logic        instr_invalid;
  logic        imem_error;
  logic        mem_ack;
  logic        dmem_error;
  logic [63:0] pc_next;
  logic [63:0] pc;
  logic        fe_en, de_en, ex_en, me_en, wb_en, pc_en;
  logic        mem_req;
  logic [1:0]  stat;
  logic        halted;
  logic [3:0]  retired;
  logic [5:0]  en;

  assign en = {fe_en, de_en, ex_en, me_en, wb_en, pc_en};

  seq_stage_sequencer #(
    .ADDR_W(64), .CNT_W(4), .RESET_PC(RPC), .WDOG_CYCLES(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .icode(icode),
    .instr_invalid(instr_invalid), .imem_error(imem_error),
    .mem_ack(mem_ack), .dmem_error(dmem_error), .pc_next(pc_next),
    .pc(pc), .fe_en(fe_en), .de_en(de_en), .ex_en(ex_en), .me_en(me_en),
    .wb_en(wb_en), .pc_en(pc_en), .mem_req(mem_req), .stat(stat),
    .halted(halted), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  icode;
    bit          inv;
    bit          imem;
    int          delay;    // MEMORY cycles before the ack cycle
    bit          derr;     // dmem_error on the ack cycle
    bit          noise;    // ack/error driven high outside the ack cycle
    logic [63:0] pcn;
    logic [1:0]  e_stat;
    bit          e_halt;
    int          e_cycles;
    int          e_req;
    bit          e_wb;
  } vec_t;

  vec_t vecs [18];
  int   nv;
  int   total  = 0;
  int   passed = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else passed++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; icode = 4'h1; instr_invalid = 1'b0; imem_error = 1'b0;
    mem_ack = 1'b0; dmem_error = 1'b0; pc_next = 64'h0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int cyc, req, memc, bad;
    bit wb, done, was_pc;
    cyc = 0; req = 0; memc = 0; bad = 0; wb = 0; done = 0;
    do_reset();
    icode = v.icode; instr_invalid = v.inv; imem_error = v.imem; pc_next = v.pcn;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int g = 0; g < 40 && !done; g++) begin
      if (halted) done = 1;
      else begin
        if ($countones(en) != 1) bad++;
        cyc++;
        if (mem_req) req++;
        if (wb_en) wb = 1;
        if (me_en) begin
          memc++;
          mem_ack    = (memc == v.delay + 1);
          dmem_error = mem_ack ? v.derr : v.noise;
        end else begin
          mem_ack    = v.noise;
          dmem_error = v.noise;
        end
        was_pc = pc_en;
        step();
        if (was_pc) done = 1;
      end
    end
    mem_ack = 1'b0; dmem_error = 1'b0;
    chk($sformatf("v%0d_done", idx), 64'(done), 64'd1);
    chk($sformatf("v%0d_stat", idx), 64'(stat), 64'(v.e_stat));
    chk($sformatf("v%0d_halted", idx), 64'(halted), 64'(v.e_halt));
    chk($sformatf("v%0d_pc", idx), pc, v.e_halt ? RPC : v.pcn);
    chk($sformatf("v%0d_retired", idx), 64'(retired), v.e_halt ? 64'd0 : 64'd1);
    chk($sformatf("v%0d_cycles", idx), 64'(cyc), 64'(v.e_cycles));
    chk($sformatf("v%0d_req_cycles", idx), 64'(req), 64'(v.e_req));
    chk($sformatf("v%0d_wb_seen", idx), 64'(wb), 64'(v.e_wb));
    chk($sformatf("v%0d_onehot_bad", idx), 64'(bad), 64'd0);
  endtask

  initial begin
    logic [5:0] pat [5];

    //            icode  inv imem dly derr noise pcn     stat  halt cyc req wb
    vecs[0]  = '{4'h6, 0, 0, 0, 0, 0, 64'h2,   2'b00, 0, 5, 0, 1};
    vecs[1]  = '{4'h5, 0, 0, 3, 0, 0, 64'h4a,  2'b00, 0, 9, 4, 1};
    vecs[2]  = '{4'h0, 0, 0, 0, 0, 0, 64'h41,  2'b01, 1, 1, 0, 0};
    vecs[3]  = '{4'h6, 1, 1, 0, 0, 0, 64'h42,  2'b10, 1, 1, 0, 0};
    vecs[4]  = '{4'h6, 1, 0, 0, 0, 0, 64'h42,  2'b11, 1, 1, 0, 0};
    vecs[5]  = '{4'h0, 0, 1, 0, 0, 0, 64'h42,  2'b10, 1, 1, 0, 0};
    vecs[6]  = '{4'h0, 1, 0, 0, 0, 0, 64'h42,  2'b11, 1, 1, 0, 0};
    vecs[7]  = '{4'h4, 0, 0, 0, 1, 0, 64'h4a,  2'b10, 1, 4, 1, 0};
    vecs[8]  = '{4'h8, 0, 0, 0, 0, 0, 64'h100, 2'b00, 0, 6, 1, 1};
    vecs[9]  = '{4'h9, 0, 0, 1, 0, 0, 64'h77,  2'b00, 0, 7, 2, 1};
    vecs[10] = '{4'hA, 0, 0, 0, 0, 0, 64'h42,  2'b00, 0, 6, 1, 1};
    vecs[11] = '{4'hB, 0, 0, 2, 0, 1, 64'h42,  2'b00, 0, 8, 3, 1};
    vecs[12] = '{4'h7, 0, 0, 0, 0, 1, 64'h1234,2'b00, 0, 5, 0, 1};
    vecs[13] = '{4'h3, 0, 0, 0, 0, 0, 64'h4a,  2'b00, 0, 5, 0, 1};
    vecs[14] = '{4'h5, 0, 0, 1, 1, 1, 64'h4a,  2'b10, 1, 5, 2, 0};
    vecs[15] = '{4'hC, 0, 0, 0, 0, 0, 64'h4a,  2'b00, 0, 5, 0, 1};
    vecs[16] = '{4'h1, 0, 0, 0, 0, 0, 64'h42,  2'b00, 0, 5, 0, 1};
    nv = 17;
`ifdef SEQ_WATCHDOG_EN
    vecs[17] = '{4'h5, 0, 0, 99, 0, 0, 64'h4a, 2'b10, 1, 7, 4, 0};
    nv = 18;
`endif

    // Reset values
    do_reset();
    chk("rst_pc", pc, RPC);
    chk("rst_stat", 64'(stat), 64'd0);
    chk("rst_retired", 64'(retired), 64'd0);
    chk("rst_halted", 64'(halted), 64'd0);
    chk("rst_mem_req", 64'(mem_req), 64'd0);
    chk("rst_en", 64'(en), 64'd0);
    step();
    chk("idle_no_start_en", 64'(en), 64'd0);

    for (int i = 0; i < nv; i++) run_vec(i, vecs[i]);

    // OPq enable pulse train with start held high, then retire-count wrap
    pat[0] = 6'b100000; pat[1] = 6'b010000; pat[2] = 6'b001000;
    pat[3] = 6'b000010; pat[4] = 6'b000001;
    do_reset();
    icode = 4'h6; pc_next = 64'h2; start = 1'b1;
    step();
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("opq_en_c%0d", c), 64'(en), 64'(pat[c]));
      chk($sformatf("opq_req_c%0d", c), 64'(mem_req), 64'd0);
      step();
    end
    chk("opq_pc", pc, 64'h2);
    chk("opq_retired", 64'(retired), 64'd1);
    chk("opq_stat", 64'(stat), 64'd0);
    chk("opq_back_fetch", 64'(en), 64'b100000);
    for (int k = 2; k <= 17; k++) begin
      pc_next = 64'(k * 16);
      repeat (5) step();
      chk($sformatf("wrap_retired_k%0d", k), 64'(retired), 64'(k % 16));
      chk($sformatf("wrap_pc_k%0d", k), pc, 64'(k * 16));
    end
    start = 1'b0;

    // Halt instruction, then start pulses must not restart the core
    do_reset();
    icode = 4'h0; pc_next = 64'h99; start = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("hlt_halted", 64'(halted), 64'd1);
    chk("hlt_stat", 64'(stat), 64'd1);
    for (int p = 0; p < 3; p++) begin
      start = 1'b1; icode = 4'h6;
      step();
      start = 1'b0;
      step();
      chk($sformatf("hlt_start%0d_en", p), 64'(en), 64'd0);
      chk($sformatf("hlt_start%0d_halted", p), 64'(halted), 64'd1);
    end
    chk("hlt_stat_after", 64'(stat), 64'd1);
    chk("hlt_pc_after", pc, RPC);
    chk("hlt_retired_after", 64'(retired), 64'd0);

    // Asynchronous reset in the middle of a MEMORY wait
    do_reset();
    icode = 4'h5; pc_next = 64'h99; start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    chk("arst_in_mem", 64'(me_en), 64'd1);
    chk("arst_req_before", 64'(mem_req), 64'd1);
    step();
    #3 rst_n = 1'b0;
    #1;
    chk("arst_req_drop", 64'(mem_req), 64'd0);
    chk("arst_pc", pc, RPC);
    chk("arst_retired", 64'(retired), 64'd0);
    chk("arst_en", 64'(en), 64'd0);
    chk("arst_stat", 64'(stat), 64'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("arst_idle_en", 64'(en), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/seq_stage_sequencer.md
# seq_stage_sequencer

Multi-cycle control sequencer for the Y86 SEQ core. It replaces the free-running clock-edge stage chaining with an explicit FSM that enables fetch, decode, execute, memory, writeback and PC-update one stage at a time, and owns the architectural PC register. It waits on a data-memory handshake, tracks the Y86 status code (AOK/HLT/ADR/INS) and counts retired instructions. It sits at the core top level, between the stage modules and the testbench or SoC wrapper.

## Interface
Parameters:
- ADDR_W, 64, width of PC and pc_next
- CNT_W, 32, width of retired-instruction counter
- RESET_PC, 0, PC value loaded at reset
- WDOG_CYCLES, 16, memory-wait limit in cycles (used only with SEQ_WATCHDOG_EN)

Ports:
- clk  in  1  core clock; all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin execution from IDLE
- icode  in  4  instruction code from fetch
- instr_invalid  in  1  fetch flags an illegal icode/ifun
- imem_error  in  1  fetch address out of range
- mem_ack  in  1  data memory access complete
- dmem_error  in  1  data memory address error, qualified by mem_ack
- pc_next  in  ADDR_W  next PC computed by the PC-update logic
- pc  out  ADDR_W  architectural PC
- fe_en, de_en, ex_en, me_en, wb_en, pc_en  out  1 each  one-hot stage enables
- mem_req  out  1  data memory request
- stat  out  2  00 AOK, 01 HLT, 10 ADR, 11 INS
- halted  out  1  core stopped; only reset clears it
- retired  out  CNT_W  instructions completed

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPD, HALT.
- IDLE: all enables low. start=1 moves to FETCH.
- FETCH (fe_en=1) checks its inputs in this priority order:
  - imem_error: stat<=ADR, go to HALT.
  - instr_invalid: stat<=INS, go to HALT.
  - icode==0 (halt): stat<=HLT, go to HALT.
  - Otherwise go to DECODE.
- DECODE goes to EXECUTE. EXECUTE goes to MEMORY if icode is in {4,5,8,9,A,B}; otherwise it goes to WRITEBACK.
- MEMORY: me_en=1 and mem_req=1 until mem_ack is sampled high.
  - mem_ack with dmem_error: stat<=ADR, go to HALT. No writeback and no PC update occur.
  - mem_ack without dmem_error: go to WRITEBACK.
- WRITEBACK goes to PCUPD. In PCUPD: pc<=pc_next, retired<=retired+1 (wraps modulo 2^CNT_W), then go to FETCH.
- HALT: all enables low, halted=1, and pc holds the PC of the faulting or halt instruction. start is ignored. Only rst_n leaves this state.
- icode is sampled only in FETCH and EXECUTE. The stage modules hold it stable for the rest of the instruction.

## Timing
- Reset values: state=IDLE, pc=RESET_PC, stat=AOK, retired=0, halted=0, mem_req=0, all enables 0.
- All outputs are driven directly from registers; no output depends combinationally on an input.
- Exactly one enable is high per cycle in stage states.
- Instruction without memory access: 5 cycles (FETCH, DECODE, EXECUTE, WRITEBACK, PCUPD).
- Instruction with memory access: 6+W cycles, where W is the number of MEMORY cycles before ack.
- mem_ack in the first MEMORY cycle gives W=0. mem_ack outside MEMORY is ignored.
- mem_req drops in the cycle after ack is sampled.
- Reset asserted mid-instruction aborts it immediately. pc and retired are not updated, and mem_req deasserts asynchronously.
- start held high continuously has no effect beyond leaving IDLE.

## Configuration
- SEQ_WATCHDOG_EN defined:
  - A wait counter runs in MEMORY and clears on entry to MEMORY.
  - If WDOG_CYCLES cycles pass without mem_ack: stat<=ADR, mem_req drops, go to HALT.
  - A mem_ack arriving in the same cycle as expiry wins.
- SEQ_WATCHDOG_EN undefined: MEMORY waits indefinitely. There is no counter logic, and WDOG_CYCLES is unused.

## Test plan
- Reset then start with icode=6 (OPq): enables pulse fe,de,ex,wb,pc on 5 consecutive cycles. pc=pc_next=0x2 after PCUPD, retired=1, stat=00.
- icode=5 (mrmovq) with mem_ack delayed 3 cycles: mem_req high for exactly 4 cycles, instruction takes 9 cycles, retired increments once.
- icode=0 at FETCH: next cycle halted=1, stat=01, pc unchanged, retired unchanged. Pulsing start afterwards has no effect.
- instr_invalid=1 and imem_error=1 together in FETCH: stat=10 (ADR wins). Then reset, rerun with instr_invalid only: stat=11.
- rmmovq with mem_ack+dmem_error: stat=10, halted=1, wb_en never asserts, pc holds the instruction address.
- SEQ_WATCHDOG_EN with WDOG_CYCLES=4 and no ack: ADR after 4 MEMORY cycles. Ack on cycle 4: normal completion. Assert rst_n low mid-MEMORY: mem_req drops immediately and pc=RESET_PC.
